// File: rtl/hazard_ctrl_pkg.sv
// Shared widths, FSM encodings and scoreboard entry type
// for the pipeline hazard controller.
package hazard_ctrl_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int PC_W       = 6;
  localparam int SB_DEPTH   = 3;
  localparam int CNT_W      = 16;

  typedef enum logic [1:0] {
    HZ_RUN      = 2'd0,
    HZ_STALL    = 2'd1,
    HZ_REDIRECT = 2'd2
  } hz_state_e;

  typedef struct packed {
    logic                  wen;
    logic [REG_ADDR_W-1:0] rd;
  } sb_entry_t;

endpackage

// File: rtl/hazard_ctrl_scoreboard.sv
// Shift-register scoreboard of in-flight register writes
// with two source-operand comparator ports.
module hz_scoreboard
  import hazard_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_wen,
  input  logic [REG_ADDR_W-1:0] push_rd,
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic                  rs1_used,
  input  logic [REG_ADDR_W-1:0] rs2,
  input  logic                  rs2_used,
  output logic                  m1,
  output logic                  m2
);

  sb_entry_t sb_q [SB_DEPTH];
  sb_entry_t sb_d [SB_DEPTH];

  always_comb begin
    sb_d[0].wen = push_wen;
    sb_d[0].rd  = push_rd;
    for (int i = 1; i < SB_DEPTH; i++) begin
      sb_d[i] = sb_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SB_DEPTH; i++) begin
        sb_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < SB_DEPTH; i++) begin
        sb_q[i] <= sb_d[i];
      end
    end
  end

  // x0 is hardwired, so it never waits on a producer
  always_comb begin
    m1 = 1'b0;
    m2 = 1'b0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      if (sb_q[i].wen && sb_q[i].rd == rs1) m1 = 1'b1;
      if (sb_q[i].wen && sb_q[i].rd == rs2) m2 = 1'b1;
    end
    m1 = m1 & rs1_used & (rs1 != '0);
    m2 = m2 & rs2_used & (rs2 != '0);
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/redirect sequencing for the five-stage core:
// RAW stalls from the scoreboard and decode-time jumps.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  resetIn,
  input  logic                  decValid,
  input  logic [REG_ADDR_W-1:0] decRs1,
  input  logic [REG_ADDR_W-1:0] decRs2,
  input  logic                  decRs1Used,
  input  logic                  decRs2Used,
  input  logic [REG_ADDR_W-1:0] decRd,
  input  logic                  decRegWrite,
  input  logic                  jumpReq,
  input  logic [PC_W-1:0]       jumpTarget,
  output logic                  pcEnable,
  output logic                  ifidEnable,
  output logic                  ifidFlush,
  output logic                  decBubble,
  output logic                  pcSelect,
  output logic [PC_W-1:0]       pcJumpAddr,
  output logic [CNT_W-1:0]      stallCycles,
  output logic [CNT_W-1:0]      flushCount
);

  hz_state_e          state_q, state_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;
  logic               m1, m2;
  logic               in_redirect;
  logic               hazard;
  logic               issue;
  logic               take_jump;

  assign in_redirect = (state_q == HZ_REDIRECT);
  assign hazard      = decValid & ~in_redirect & (m1 | m2);
  assign issue       = decValid & ~in_redirect & ~hazard;
  assign take_jump   = issue & jumpReq;

  hz_scoreboard u_sb (
    .clk      (clk),
    .rst      (resetIn),
    .push_wen (issue & decRegWrite),
    .push_rd  (decRd),
    .rs1      (decRs1),
    .rs1_used (decRs1Used),
    .rs2      (decRs2),
    .rs2_used (decRs2Used),
    .m1       (m1),
    .m2       (m2)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      HZ_RUN, HZ_STALL: begin
        if (hazard)         state_d = HZ_STALL;
        else if (take_jump) state_d = HZ_REDIRECT;
        else                state_d = HZ_RUN;
      end
      HZ_REDIRECT: state_d = HZ_RUN;
      default:     state_d = HZ_RUN;
    endcase
  end

  always_comb begin
    pcEnable   = 1'b1;
    ifidEnable = 1'b1;
    ifidFlush  = 1'b0;
    decBubble  = 1'b0;
    pcSelect   = 1'b0;
    pcJumpAddr = '0;
    unique case (1'b1)
      hazard: begin
        pcEnable   = 1'b0;
        ifidEnable = 1'b0;
        decBubble  = 1'b1;
      end
      take_jump: begin
        pcSelect   = 1'b1;
        pcJumpAddr = jumpTarget;
        ifidFlush  = 1'b1;
      end
      in_redirect: decBubble = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (hazard && stall_cnt_q != '1)
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (take_jump && flush_cnt_q != '1)
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (resetIn) begin
      state_q     <= HZ_RUN;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stallCycles = stall_cnt_q;
  assign flushCount  = flush_cnt_q;

endmodule
